// File: rtl/serial_bus_pkg.sv
// Shared widths and master state encoding for the serial bus endpoints.
package serial_bus_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int BURST_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_WDATA,
        ST_RWAIT,
        ST_RDATA,
        ST_SPLIT
    } mst_state_e;

endpackage

// File: rtl/master_shift_reg.sv
// Loadable right-shift register: parallel load, serial in at the MSB,
// LSB presented as the serial output.
module master_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic             lsb_o
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= din_i;
        end else if (shift_i) begin
            sr_q <= {sin_i, sr_q[WIDTH-1:1]};
        end
    end

    assign lsb_o = sr_q[0];

endmodule

// File: rtl/master_port.sv
// Serial bus master endpoint: serializes address/burst/write data per request
// and deserializes read bytes, with bounded tolerance of slave split stalls.
module master_port
    import serial_bus_pkg::*;
#(
    parameter int SPLIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [11:0] req_addr,
    input  logic        req_burst_en,
    input  logic [11:0] req_burst_len,
    input  logic [7:0]  wdata,
    output logic        wdata_ack,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        read_enable,
    output logic        write_enable,
    output logic        m_valid,
    input  logic        s_ready,
    output logic        tx_address,
    output logic        tx_burst,
    output logic        tx_data,
    output logic        m_ready,
    input  logic        s_valid,
    input  logic        rx_data,
    input  logic        split_enable
);

    localparam logic [7:0] SPLIT_LAST = 8'(SPLIT_TIMEOUT - 1);
    localparam logic [3:0] ADDR_LAST  = 4'(ADDR_W);
    localparam logic [3:0] WDATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] RX_LAST    = 4'(DATA_W);

    mst_state_e  state_q, state_d, ret_q;
    logic [3:0]  bit_cnt_q;
    logic [12:0] beats_q;
    logic [7:0]  split_cnt_q;
    logic        first_q;
    logic [7:0]  rx_sr_q, rdata_q;
    logic        wdata_ack_q, rdata_valid_q, done_q, err_q, busy_q;
    logic        re_q, we_q, m_valid_q, m_ready_q;

    logic accept, hs, beat_end, abort, rx_sample, rx_pub;
    logic last_beat, next_wd, finish, shift_ab, shift_d;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hs        = 1'b0;
        beat_end  = 1'b0;
        abort     = 1'b0;
        rx_sample = 1'b0;
        rx_pub    = 1'b0;
        case (state_q)
            ST_IDLE:  if (req_valid) begin
                          accept  = 1'b1;
                          state_d = ST_REQ;
                      end
            ST_REQ:   if (s_ready) begin
                          hs      = 1'b1;
                          state_d = first_q ? ST_ADDR : ST_WDATA;
                      end else if (split_enable) begin
                          state_d = ST_SPLIT;
                      end
            ST_ADDR:  beat_end = (bit_cnt_q == ADDR_LAST);
            ST_WDATA: beat_end = (bit_cnt_q == WDATA_LAST);
            ST_RWAIT: if (s_valid) begin
                          rx_sample = 1'b1;
                          state_d   = ST_RDATA;
                      end else if (split_enable) begin
                          state_d = ST_SPLIT;
                      end
            ST_RDATA: begin
                          rx_pub    = (bit_cnt_q == RX_LAST);
                          rx_sample = !rx_pub;
                      end
            ST_SPLIT: if (!split_enable) begin
                          state_d = ret_q;
                      end else if (split_cnt_q == SPLIT_LAST) begin
                          abort   = 1'b1;
                          state_d = ST_IDLE;
                      end
            default:  state_d = ST_IDLE;
        endcase

        last_beat = (beats_q == 13'd1);
        next_wd   = beat_end && we_q && !last_beat;
        finish    = (beat_end && we_q && last_beat) || (rx_pub && last_beat);
        if (beat_end) begin
            state_d = !we_q ? ST_RWAIT : (last_beat ? ST_IDLE : ST_REQ);
        end
        if (rx_pub) begin
            state_d = last_beat ? ST_IDLE : ST_RWAIT;
        end
        // Address/burst only stream on the first beat; later beats carry data only.
        shift_ab = (hs && first_q) || (state_q == ST_ADDR);
        shift_d  = hs || (state_q == ST_ADDR) || (state_q == ST_WDATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ret_q         <= ST_IDLE;
            bit_cnt_q     <= '0;
            beats_q       <= '0;
            split_cnt_q   <= '0;
            first_q       <= 1'b0;
            rx_sr_q       <= '0;
            rdata_q       <= '0;
            wdata_ack_q   <= 1'b0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            re_q          <= 1'b0;
            we_q          <= 1'b0;
            m_valid_q     <= 1'b0;
            m_ready_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= (state_d != ST_IDLE);
            m_valid_q     <= (state_d == ST_REQ);
            m_ready_q     <= (state_d == ST_RWAIT);
            wdata_ack_q   <= (accept && !req_rw) || next_wd;
            done_q        <= finish;
            err_q         <= abort;
            rdata_valid_q <= rx_pub;
            bit_cnt_q     <= (state_d != state_q) ? 4'd1 : bit_cnt_q + 4'd1;
            split_cnt_q   <= (state_q == ST_SPLIT && state_d == ST_SPLIT) ?
                             split_cnt_q + 8'd1 : '0;
            if (state_d == ST_SPLIT && state_q != ST_SPLIT) begin
                ret_q <= state_q;
            end
            if (rx_sample) begin
                rx_sr_q <= {rx_data, rx_sr_q[7:1]};
            end
            if (rx_pub) begin
                rdata_q <= rx_sr_q;
            end
            if (hs) begin
                first_q <= 1'b0;
            end
            if (accept) begin
                re_q    <= req_rw;
                we_q    <= !req_rw;
                first_q <= 1'b1;
                beats_q <= req_burst_en ? {1'b0, req_burst_len} + 13'd1 : 13'd1;
            end else begin
                if (state_d == ST_IDLE) begin
                    re_q <= 1'b0;
                    we_q <= 1'b0;
                end
                if (next_wd || rx_pub) begin
                    beats_q <= beats_q - 13'd1;
                end
            end
        end
    end

    master_shift_reg #(.WIDTH(ADDR_W)) u_addr_sr (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (accept || abort),
        .din_i   (accept ? req_addr : '0),
        .shift_i (shift_ab),
        .sin_i   (1'b0),
        .lsb_o   (tx_address)
    );

    master_shift_reg #(.WIDTH(BURST_W)) u_burst_sr (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (accept || abort),
        .din_i   ((accept && req_burst_en) ? {req_burst_len, 1'b1} : '0),
        .shift_i (shift_ab),
        .sin_i   (1'b0),
        .lsb_o   (tx_burst)
    );

    master_shift_reg #(.WIDTH(DATA_W)) u_data_sr (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (accept || next_wd || abort),
        .din_i   ((next_wd || (accept && !req_rw)) ? wdata : '0),
        .shift_i (shift_d),
        .sin_i   (1'b0),
        .lsb_o   (tx_data)
    );

    assign req_ready    = (state_q == ST_IDLE);
    assign wdata_ack    = wdata_ack_q;
    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign read_enable  = re_q;
    assign write_enable = we_q;
    assign m_valid      = m_valid_q;
    assign m_ready      = m_ready_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: table of single-beat transactions plus
// hand-written burst, split, timeout and mid-transaction reset sequences.
module tb_master_port;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_rw, req_burst_en;
    logic [11:0] req_addr, req_burst_len;
    logic [7:0]  wdata, rdata;
    logic        req_ready, wdata_ack, rdata_valid, done, err, busy;
    logic        read_enable, write_enable, m_valid, s_ready;
    logic        tx_address, tx_burst, tx_data, m_ready, s_valid, rx_data, split_enable;

    always #5 clk = ~clk;

    master_port #(.SPLIT_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_burst_en(req_burst_en),
        .req_burst_len(req_burst_len), .wdata(wdata), .wdata_ack(wdata_ack),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
        .busy(busy), .read_enable(read_enable), .write_enable(write_enable),
        .m_valid(m_valid), .s_ready(s_ready), .tx_address(tx_address),
        .tx_burst(tx_burst), .tx_data(tx_data), .m_ready(m_ready),
        .s_valid(s_valid), .rx_data(rx_data), .split_enable(split_enable)
    );

    int nvec = 0;
    int nerr = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (!reset && err) err_cnt++;
    end

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic        ben;
        logic [11:0] len;
        logic [7:0]  wd;
        logic [7:0]  rx;
        int          rwait;
        logic [12:0] exp_addr;
        logic [12:0] exp_burst;
        logic [12:0] exp_data;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vt [5];

    int          acks, hss, beat;
    logic [12:0] bst;
    logic [7:0]  bytes_q [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] outs();
        return {busy, m_valid, m_ready, tx_address, tx_burst, tx_data,
                wdata_ack, rdata_valid, done, err, read_enable, write_enable};
    endfunction

    function automatic logic [7:0] pat(input int k);
        return (k < 4) ? 8'((k + 1) * 17) : k[7:0];
    endfunction

    task automatic issue(input logic rw, input logic [11:0] a, input logic ben,
                         input logic [11:0] len, input logic [7:0] wd);
        req_valid = 1'b1; req_rw = rw; req_addr = a;
        req_burst_en = ben; req_burst_len = len; wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    // Drives one byte LSB first; returns right after the edge sampling bit 7.
    task automatic slave_byte(input logic [7:0] b);
        s_valid = 1'b1;
        rx_data = b[0];
        tick();
        s_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            rx_data = b[k];
            tick();
        end
        rx_data = 1'b0;
    endtask

    task automatic run_txn(input int i);
        logic [12:0] ga, gb, gd;
        int early, e0;
        string tag;
        tag = $sformatf("v%0d", i);
        e0 = err_cnt;
        early = 0;
        s_ready = 1'b1; s_valid = 1'b0; split_enable = 1'b0; rx_data = 1'b0;
        chk({tag, "_req_ready_idle"}, req_ready, 1'b1);
        issue(vt[i].rw, vt[i].addr, vt[i].ben, vt[i].len, vt[i].wd);
        chk({tag, "_req_state"}, {req_ready, m_valid, wdata_ack, read_enable, write_enable, busy},
            {1'b0, 1'b1, !vt[i].rw, vt[i].rw, !vt[i].rw, 1'b1});
        for (int c = 0; c < 13; c++) begin
            ga[c] = tx_address;
            gb[c] = tx_burst;
            gd[c] = tx_data;
            if (done) early++;
            tick();
        end
        chk({tag, "_tx_address"}, ga, vt[i].exp_addr);
        chk({tag, "_tx_burst"}, gb, vt[i].exp_burst);
        chk({tag, "_tx_data"}, gd, vt[i].exp_data);
        chk({tag, "_no_early_done"}, early, 0);
        if (!vt[i].rw) begin
            chk({tag, "_wr_done_13"}, {done, busy, write_enable}, 3'b100);
        end else begin
            chk({tag, "_rwait"}, {done, m_ready, busy}, 3'b011);
            repeat (vt[i].rwait) tick();
            chk({tag, "_rwait_hold"}, m_ready, 1'b1);
            slave_byte(vt[i].rx);
            chk({tag, "_rd_done_not_yet"}, {done, rdata_valid}, 2'b00);
            tick();
            chk({tag, "_rd_done_9"}, {done, rdata_valid, busy}, 3'b110);
            chk({tag, "_rdata"}, rdata, vt[i].exp_rdata);
        end
        tick();
        chk({tag, "_after"}, {done, rdata_valid, busy, req_ready}, 4'b0001);
        chk({tag, "_no_err"}, err_cnt, e0);
    endtask

    task automatic wburst(input logic [11:0] len, input int maxc, output int ncyc, output logic fin);
        int cap, n;
        logic [7:0] cur;
        acks = 0; hss = 0; beat = 0; cap = -1; n = 0; fin = 1'b0; bst = '0; cur = '0;
        s_ready = 1'b1; split_enable = 1'b0;
        issue(1'b0, 12'h0F0, 1'b1, len, pat(0));
        while (!fin && n < maxc) begin
            if (wdata_ack) begin
                acks++;
                wdata = pat(acks);
            end
            if (m_valid && s_ready) begin
                hss++;
                cap = 0;
            end
            if (n < 13) bst[n] = tx_burst;
            if (cap >= 0 && cap < 8) begin
                cur[cap] = tx_data;
                cap++;
                if (cap == 8) begin
                    if (beat < 4) bytes_q[beat] = cur;
                    beat++;
                end
            end
            if (done) fin = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        ncyc = n;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ncyc, first, bad, e0;
        logic fin;

        vt[0] = '{1'b0, 12'hABC, 1'b0, 12'h5A5, 8'h5A, 8'h00, 0, 13'h0ABC, 13'h0000, 13'h005A, 8'h00};
        vt[1] = '{1'b1, 12'h123, 1'b0, 12'h007, 8'hEE, 8'hC3, 5, 13'h0123, 13'h0000, 13'h0000, 8'hC3};
        vt[2] = '{1'b0, 12'h001, 1'b1, 12'h000, 8'h80, 8'h00, 0, 13'h0001, 13'h0001, 13'h0080, 8'h00};
        vt[3] = '{1'b1, 12'hFFF, 1'b1, 12'h000, 8'h00, 8'h3C, 0, 13'h0FFF, 13'h0001, 13'h0000, 8'h3C};
        vt[4] = '{1'b0, 12'h800, 1'b0, 12'h000, 8'hFF, 8'h00, 0, 13'h0800, 13'h0000, 13'h00FF, 8'h00};

        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_burst_en = 1'b0; req_burst_len = '0; wdata = '0;
        s_ready = 1'b0; s_valid = 1'b0; rx_data = 1'b0; split_enable = 1'b0;
        tick();
        tick();
        chk("reset_outputs", outs(), 12'h000);
        chk("reset_rdata", rdata, 8'h00);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_txn(i);

        // Four-beat write burst.
        e0 = err_cnt;
        wburst(12'd3, 200, ncyc, fin);
        chk("burst3_done", fin, 1'b1);
        chk("burst3_cycles", ncyc, 37);
        chk("burst3_acks", acks, 4);
        chk("burst3_handshakes", hss, 4);
        chk("burst3_tx_burst", bst, 13'h0007);
        for (int k = 0; k < 4; k++) chk($sformatf("burst3_byte%0d", k), bytes_q[k], pat(k));
        tick();
        chk("burst3_single_done", {done, busy}, 2'b00);
        chk("burst3_no_err", err_cnt, e0);

        // Read stalled by a 10-cycle split while waiting for data.
        e0 = err_cnt;
        s_ready = 1'b1;
        issue(1'b1, 12'h2A5, 1'b0, 12'h000, 8'h00);
        repeat (13) tick();
        chk("split_rwait_mready", m_ready, 1'b1);
        split_enable = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (m_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0) bad++;
        end
        chk("split_hold_lines", bad, 0);
        split_enable = 1'b0;
        tick();
        chk("split_resume_mready", m_ready, 1'b1);
        slave_byte(8'h96);
        tick();
        chk("split_read_done", {done, rdata_valid, rdata}, {2'b11, 8'h96});
        tick();
        chk("split_read_no_err", err_cnt, e0);

        // Split held in REQ until the timeout fires.
        e0 = err_cnt;
        s_ready = 1'b0;
        split_enable = 1'b1;
        issue(1'b0, 12'h3C3, 1'b0, 12'h000, 8'h77);
        chk("timeout_req_mvalid", m_valid, 1'b1);
        first = -1;
        bad = 0;
        for (int t = 1; t <= 40 && first < 0; t++) begin
            tick();
            if (done) bad++;
            if (err) first = t;
            else if (m_valid !== 1'b0) bad++;
        end
        chk("timeout_err_cycle", first, 17);
        chk("timeout_no_done_mvalid", bad, 0);
        chk("timeout_idle", {busy, write_enable, req_ready}, 3'b001);
        tick();
        chk("timeout_err_pulse", {err, done}, 2'b00);
        chk("timeout_err_count", err_cnt, e0 + 1);
        split_enable = 1'b0;
        s_ready = 1'b1;

        // Reset in the fifth ADDR cycle, then a normal transaction.
        e0 = err_cnt;
        issue(1'b0, 12'h555, 1'b0, 12'h000, 8'hA5);
        repeat (5) tick();
        chk("rst_mid_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_mid_outputs", outs(), 12'h000);
        chk("rst_mid_rdata", rdata, 8'h00);
        reset = 1'b0;
        tick();
        chk("rst_mid_no_err", err_cnt, e0);
        run_txn(0);

        // Maximum burst length: 4096 beats.
        wburst(12'hFFF, 40000, ncyc, fin);
        chk("burst4096_done", fin, 1'b1);
        chk("burst4096_cycles", ncyc, 13 + 8 * 4095);
        chk("burst4096_acks", acks, 4096);
        chk("burst4096_tx_burst", bst, 13'h1FFF);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/master_port.md
# master_port

Bus-master endpoint of the serial bus. Accepts parallel read/write requests (single or burst) from a local master device and serializes address, burst descriptor and write data onto the bus lines. It deserializes read data returned by the slave and tolerates slave-initiated split stalls. It sits directly upstream of the slave port: its tx lines are the slave's rx lines, and it consumes the slave's tx_data/s_valid/split_enable.

## Interface
Parameters:
- SPLIT_TIMEOUT, 64: maximum consecutive split cycles before abort (≥1, ≤255).

Ports:
- clk  in  1  clock; every flop updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  12  start address.
- req_burst_en  in  1  burst enable.
- req_burst_len  in  12  burst beats minus 1; ignored when req_burst_en = 0.
- wdata  in  8  write byte for the current beat.
- wdata_ack  out  1  1-cycle pulse: wdata latched for a beat.
- rdata  out  8  last received read byte.
- rdata_valid  out  1  1-cycle pulse per received byte.
- done  out  1  1-cycle pulse at transaction completion.
- err  out  1  1-cycle pulse on split timeout.
- busy  out  1  high whenever state ≠ IDLE.
- read_enable, write_enable  out  1  transaction type, held for the whole transaction.
- m_valid  out  1  master-valid, beat handshake with s_ready.
- s_ready  in  1  slave ready.
- tx_address  out  1  serial address, LSB first.
- tx_burst  out  1  serial 13-bit burst field {len[11:0], en}, LSB first.
- tx_data  out  1  serial write data, LSB first.
- m_ready  out  1  master ready for read data.
- s_valid  in  1  slave read data valid.
- rx_data  in  1  serial read data, LSB first.
- split_enable  in  1  slave split stall.

## Operation
- States: IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, SPLIT.
- IDLE: req_valid & req_ready latches request; beats = burst_en ? len+1 : 1; write latches wdata with a wdata_ack pulse → REQ.
- REQ: m_valid = 1. Lines pre-drive bit 0: tx_address = addr[0], tx_burst = burst[0], tx_data = wdata[0] on write. Edge with m_valid & s_ready = handshake.
  - First beat → ADDR.
  - Later write beats → WDATA.
  - split_enable high (no handshake) → SPLIT.
- ADDR: 12 cycles. Bit k of address/burst/data is driven in cycle k after handshake. Burst bit 12 is driven in cycle 12.
  - Write data bits 1–7 run concurrently.
  - Exit: write with beats remaining → latch next wdata (wdata_ack) → REQ; otherwise done. Read → RWAIT.
- WDATA (later write beats): bits 1–7 over 7 cycles; tx_address/tx_burst = 0. Then next beat or done.
- RWAIT: m_ready = 1.
  - Edge with s_valid & m_ready samples rx_data bit 0 → RDATA.
  - split_enable → SPLIT.
- RDATA: samples bits 1–7 on the next 7 edges, then pulses rdata_valid with rdata updated.
  - Beats remaining → RWAIT; else done → IDLE.
- SPLIT: m_valid = m_ready = 0; line values held; 8-bit counter increments.
  - split_enable low → return to the saved state (REQ or RWAIT); counter clears.
  - Counter reaches SPLIT_TIMEOUT → err pulse, abort to IDLE, no done.
- split_enable is ignored during ADDR, WDATA and RDATA.
- Beat counter: 13-bit, compared exactly; len = 0xFFF yields 4096 beats.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-transaction aborts immediately: no done, no err.
- req_ready is combinational from state; all other outputs are registered.
- Single write: done pulses 13 cycles after handshake.
- Single read, slave answering immediately: done pulses 9 cycles after the s_valid handshake edge.
- Simultaneous handshake and split_enable in REQ/RWAIT: the handshake wins.
- done and rdata_valid on the final read beat assert in the same cycle.

## Structure
- Package serial_bus_pkg: ADDR_W = 12, DATA_W = 8, BURST_W = 13, master state enum.
- One sub-module, master_shift_reg: parameterized-width PISO/SIPO with load, shift, and LSB output.
- Three instances: address, burst, data.

## Test plan
- Write 0xABC / 0x5A, s_ready held high: tx_address = 0,0,1,1,1,1,0,1,0,1,0,1; tx_data = 0,1,0,1,1,0,1,0; tx_burst all 0; done at +13.
- Read 0x123, slave returns 0xC3 after 5 RWAIT cycles: rdata = 0xC3, one rdata_valid, done together.
- Write burst, len = 3: four wdata_ack pulses, four handshakes, tx_burst = 1,1,1,0…0, single done.
- Read with split_enable for 10 cycles in RWAIT: m_ready = 0 during split; resumes and completes; no err.
- split_enable held with SPLIT_TIMEOUT = 16: err pulses after 16 cycles, busy drops, no done.
- Reset asserted in ADDR cycle 5: all outputs 0 next cycle; a new request then succeeds.
